ram_burst_reader: RTL
=====================

# ram_burst_reader

Burst read engine for port B of the 256 x 32 dual-port data RAM. The Control block writes results through port A; this block is the reading side. On a start request it walks a contiguous, wrapping address range and streams each word out on a valid/ready interface, with a last-word marker and a completion pulse. It owns `addrb` and consumes `doutb`. The RAM read latency is a fixed 1 cycle.

## Interface
- `ADDR_W`, 8: RAM address width. The depth is 2^ADDR_W words.
- `DATA_W`, 32: RAM word width.
- `LEN_W`, 9: burst length field width. Holds lengths 0..2^ADDR_W.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `length`  in  LEN_W  number of words; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `addrb`  out  ADDR_W  RAM port B read address (registered).
- `doutb`  in  DATA_W  RAM port B read data; valid 1 cycle after `addrb` is sampled by the RAM.
- `m_data`  out  DATA_W  streamed word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_last`  out  1  qualifies the final word of the burst.

## Operation
- Reset values: `busy`=0, `done`=0, `addrb`=0, `m_data`=0, `m_valid`=0, `m_last`=0. The FSM goes to IDLE, all counters clear, and the output buffer empties.
- States:
  - IDLE → RUN on `start` with `length`≠0.
  - IDLE → FIN on `start` with `length`=0.
  - RUN → FIN when the last word is handshaked.
  - FIN → IDLE unconditionally.
- `done` is high exactly during FIN.
- `start` is ignored outside IDLE. `base_addr` and `length` are ignored unless `start` is accepted.
- Read issue:
  - An issue counter holds the remaining words to issue. `addrb` advances by 1 per issued read.
  - Addresses wrap modulo 2^ADDR_W: 8'hFF → 8'h00.
- Output buffer:
  - 2 entries. Each returning `doutb` word is written into the buffer in the cycle after issue.
  - A read is issued only when occupancy plus in-flight reads, minus any pop in the same cycle, is at most 1. The buffer therefore never overflows, and no read is issued whose data could be lost.
- Handshake:
  - A word transfers on a cycle with `m_valid`&&`m_ready`.
  - While `m_valid`=1 and `m_ready`=0, `m_data`, `m_valid` and `m_last` hold stable.
  - `m_valid` never drops without a transfer.
- `m_last`=1 only together with the word whose handshake makes the delivered count equal `length`.
- Width rules: `length` of 2^ADDR_W (256) is legal. It reads every RAM word once, starting at `base_addr`.
- Reset mid-burst: in-flight data is discarded, no `done` pulse is produced, and outputs return to their reset values on the next edge.

## Timing
- Cycle numbering: start accepted at the edge ending cycle 0.
  - Cycle 1: `busy`=1, `addrb`=`base_addr`.
  - Cycle 2: `doutb` valid.
  - Cycle 3: `m_valid`=1 with word 0.
- First-word latency is 3 cycles from the accepting edge.
- Throughput is 1 word/cycle while `m_ready` is held high: no bubbles after the first word.
- `done` is asserted in the cycle after the last handshake. `busy` falls in that same cycle. A new `start` is accepted in that cycle's IDLE successor, so back-to-back bursts have a gap of 2 cycles.
- Zero-length burst: `done` in cycle 1; `m_valid` is never asserted.
- Backpressure: at most 2 words are outstanding, whether buffered or in flight. Reads resume within 1 cycle of `m_ready` returning high.

## Test plan
- RAM[0x10..0x13]=A0..A3, `start` with base=0x10, len=4, `m_ready`=1 → A0,A1,A2,A3 on 4 consecutive cycles starting at cycle 3. `m_last` is set on A3. `done` pulses in cycle 7.
- base=0xFE, len=4 → addresses FE,FF,00,01 read in order, with wrap and no stall.
- len=8, `m_ready` toggling 1,0,0,1,… → all 8 words delivered once, in order. Data is stable during stalls. `addrb` never runs more than 2 words ahead of delivered data.
- len=0 → `done`=1 in cycle 1, `busy` never rises, `m_valid` stays 0. A `start` pulse mid-burst is ignored, and the burst length is unchanged.
- len=256 from base=0x80 → 256 words, the last from 0x7F, `m_last` exactly once.
- `rst` asserted at word 3 of a len=10 burst → next cycle all outputs are 0 and no `done` occurs. A following burst with len=2 streams correctly.

Source files
------------

// File: rtl/ram_burst_reader.sv
//============================================================================
// Module      : ram_burst_reader
// Description : Burst read engine for port B of the data RAM. Walks a
//               contiguous, wrapping address range and streams each word
//               on a valid/ready interface, with a last marker and a
//               completion pulse.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_burst_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]  C_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  C_LEN_ZERO = '0;
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]   deliv_q, deliv_d;
    logic [ADDR_W-1:0]  addrb_q, addrb_d;
    logic               inflight_q, inflight_d;
    // Two-entry output buffer: head drives the stream, skid absorbs one
    // extra returning word while the head is stalled.
    logic [DATA_W-1:0]  head_q, head_d;
    logic               head_vld_q, head_vld_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               skid_vld_q, skid_vld_d;

    logic               w_pop;
    logic               w_last;
    logic [1:0]         w_load;
    logic               w_issue;

    assign w_pop  = head_vld_q && m_ready;
    assign w_last = ((deliv_q + C_LEN_ONE) == len_q);
    // Buffered plus in-flight words after this cycle's pop; never exceeds 2.
    assign w_load = {1'b0, head_vld_q} + {1'b0, skid_vld_q}
                  + {1'b0, inflight_q} - {1'b0, w_pop};
    assign w_issue = (state_q == S_RUN) && (issue_cnt_q != C_LEN_ZERO)
                  && (w_load <= 2'd1);

    // Next-state, address/counter update and output-buffer steering.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        deliv_d     = deliv_q;
        addrb_d     = addrb_q;
        inflight_d  = w_issue;
        head_d      = head_q;
        head_vld_d  = head_vld_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = length;
                    issue_cnt_d = length;
                    deliv_d     = C_LEN_ZERO;
                    addrb_d     = base_addr;
                    state_d     = (length == C_LEN_ZERO) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    addrb_d     = addrb_q + C_ADDR_ONE;
                    issue_cnt_d = issue_cnt_q - C_LEN_ONE;
                end
                if (w_pop) begin
                    deliv_d = deliv_q + C_LEN_ONE;
                    if (w_last) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // doutb is valid the cycle after an issue; land it in the buffer.
        if (w_pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = inflight_q;
                if (inflight_q) begin
                    skid_d = doutb;
                end
            end else begin
                head_vld_d = inflight_q;
                if (inflight_q) begin
                    head_d = doutb;
                end
            end
        end else if (inflight_q) begin
            if (!head_vld_q) begin
                head_d     = doutb;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = doutb;
                skid_vld_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset; in-flight data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            deliv_q     <= '0;
            addrb_q     <= '0;
            inflight_q  <= 1'b0;
            head_q      <= '0;
            head_vld_q  <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            deliv_q     <= deliv_d;
            addrb_q     <= addrb_d;
            inflight_q  <= inflight_d;
            head_q      <= head_d;
            head_vld_q  <= head_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_FIN);
    assign addrb   = addrb_q;
    assign m_data  = head_q;
    assign m_valid = head_vld_q;
    assign m_last  = head_vld_q && w_last;

endmodule

`default_nettype wire
